// File: rtl/mdu_sequencer.sv
// E-stage multiply/divide sequencer owning the HI/LO pair.
// Results are computed at issue, held while busy, and committed when the latency counter expires.
module mdu_sequencer #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] rs_val_i,
    input  logic [31:0] rt_val_i,
    input  logic        rd_hi_i,
    output logic        busy_o,
    output logic        md_active_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic [31:0] rd_data_o
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = (MaxCycles > 15) ? $clog2(MaxCycles + 1) : 4;

    localparam logic [CntW-1:0] MultLoad = MULT_CYCLES[CntW-1:0];
    localparam logic [CntW-1:0] DivLoad  = DIV_CYCLES[CntW-1:0];
    localparam logic [CntW-1:0] CntOne   = {{(CntW-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic [31:0]     res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic            res_vld_q, res_vld_d;

    logic        is_md_op;
    logic        accept;
    logic        busy;
    logic [63:0] a_sx, b_sx, prod_s, prod_u;
    logic        div_signed, dvd_neg, dvs_neg, div_zero;
    logic [31:0] dvd_mag, dvs_mag, dvs_safe, q_mag, r_mag, quot, rem;

    assign is_md_op = start_i & (op_i <= 3'd3);
    assign accept   = (state_q == StIdle) & start_i;

    // Low 64 bits of a sign-extended product equal the signed 32x32 product.
    assign a_sx   = {{32{rs_val_i[31]}}, rs_val_i};
    assign b_sx   = {{32{rt_val_i[31]}}, rt_val_i};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, rs_val_i} * {32'd0, rt_val_i};

    // Sign-magnitude division; 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
    assign div_signed = ~op_i[0];
    assign dvd_neg    = div_signed & rs_val_i[31];
    assign dvs_neg    = div_signed & rt_val_i[31];
    assign div_zero   = (rt_val_i == 32'd0);
    assign dvd_mag    = dvd_neg ? (~rs_val_i + 32'd1) : rs_val_i;
    assign dvs_mag    = dvs_neg ? (~rt_val_i + 32'd1) : rt_val_i;
    assign dvs_safe   = div_zero ? 32'd1 : dvs_mag;
    assign q_mag      = dvd_mag / dvs_safe;
    assign r_mag      = dvd_mag % dvs_safe;
    assign quot       = (dvd_neg ^ dvs_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem        = dvd_neg ? (~r_mag + 32'd1) : r_mag;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            res_hi_q  <= '0;
            res_lo_q  <= '0;
            res_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            res_hi_q  <= res_hi_d;
            res_lo_q  <= res_lo_d;
            res_vld_q <= res_vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (is_md_op) begin
                    state_d = StRun;
                    cnt_d   = op_i[1] ? DivLoad : MultLoad;
                end
            end
            StRun: begin
                cnt_d = cnt_q - CntOne;
                if (cnt_q == CntOne) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        res_hi_d  = res_hi_q;
        res_lo_d  = res_lo_q;
        res_vld_d = res_vld_q;
        if (accept && is_md_op) begin
            unique case (op_i[1:0])
                2'd0: begin
                    {res_hi_d, res_lo_d} = prod_s;
                    res_vld_d            = 1'b1;
                end
                2'd1: begin
                    {res_hi_d, res_lo_d} = prod_u;
                    res_vld_d            = 1'b1;
                end
                default: begin
                    res_hi_d  = rem;
                    res_lo_d  = quot;
                    res_vld_d = ~div_zero;
                end
            endcase
        end
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (accept && op_i == 3'd4) begin
            hi_d = rs_val_i;
        end
        if (accept && op_i == 3'd5) begin
            lo_d = rs_val_i;
        end
        if (state_q == StRun && cnt_q == CntOne && res_vld_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
        end
    end

    always_comb begin
        busy        = (state_q == StRun);
        busy_o      = busy;
        md_active_o = busy | is_md_op;
        hi_o        = hi_q;
        lo_o        = lo_q;
        rd_data_o   = rd_hi_i ? hi_q : lo_q;
    end

endmodule
